// File: rtl/onchip_mem_bist_master_if.sv
// Avalon-MM port between the BIST master and the single-port on-chip RAM slave.
interface onchip_mem_bist_master_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [3:0]            mem_byteenable;
  logic                  mem_chipselect;
  logic                  mem_write;
  logic [31:0]           mem_writedata;
  logic                  mem_clken;
  logic [31:0]           mem_readdata;

  modport master (
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport slave (
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/onchip_mem_bist_master.sv
// Two-pass (pattern, inverted pattern) write-then-read BIST over an on-chip RAM.
// Reports pass/fail, first failing address/data and a saturating mismatch count.
module onchip_mem_bist_master #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DEPTH      = 1022,
  parameter logic [31:0] SEED       = 32'hA5C3_0F96
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [31:0]           fail_data,
  onchip_mem_bist_master_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_WR0, S_RD0, S_DRN0, S_WR1, S_RD1, S_DRN1} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic                  cmp_vld;
  logic [31:0]           exp_q;
  logic [ADDR_WIDTH-1:0] cmp_addr;
  logic                  have_fail;
  logic                  mismatch;
  logic                  launch;
  logic [7:0]            err_nxt;
  logic                  cs_nxt, wr_nxt;
  logic [31:0]           wdata_nxt;
  logic [ADDR_WIDTH-1:0] maddr_nxt;

  function automatic logic [31:0] pattern(input logic [ADDR_WIDTH-1:0] a, input logic inv);
    logic [31:0] p;
    p = SEED ^ 32'(a);
    return inv ? ~p : p;
  endfunction

  assign busy               = (state != S_IDLE);
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_clken      = 1'b1;
  assign launch             = (state == S_IDLE) && start && !abort;
  assign mismatch           = cmp_vld && (bus.mem_readdata != exp_q);

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    unique case (state)
      S_IDLE: if (start) begin
        state_nxt = S_WR0;
        addr_nxt  = '0;
      end
      S_WR0, S_RD0, S_WR1, S_RD1: begin
        addr_nxt = (addr == LAST) ? '0 : addr + ADDR_WIDTH'(1);
        if (addr == LAST) begin
          state_nxt = (state == S_WR0) ? S_RD0 :
                      (state == S_RD0) ? S_DRN0 :
                      (state == S_WR1) ? S_RD1 : S_DRN1;
        end
      end
      S_DRN0:  state_nxt = S_WR1;
      S_DRN1:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      addr_nxt  = '0;
    end

    // Bus outputs are registered, so they are derived from the upcoming state/address.
    cs_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    wdata_nxt = '0;
    maddr_nxt = bus.mem_address;
    if (state_nxt == S_WR0 || state_nxt == S_WR1) begin
      cs_nxt    = 1'b1;
      wr_nxt    = 1'b1;
      wdata_nxt = pattern(addr_nxt, state_nxt == S_WR1);
      maddr_nxt = addr_nxt;
    end else if (state_nxt == S_RD0 || state_nxt == S_RD1) begin
      cs_nxt    = 1'b1;
      maddr_nxt = addr_nxt;
    end

    err_nxt = err_count;
    if (launch)
      err_nxt = '0;
    else if (mismatch && err_count != 8'hFF)
      err_nxt = err_count + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      addr               <= '0;
      bus.mem_address    <= '0;
      bus.mem_chipselect <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.mem_writedata  <= '0;
    end else begin
      state              <= state_nxt;
      addr               <= addr_nxt;
      bus.mem_address    <= maddr_nxt;
      bus.mem_chipselect <= cs_nxt;
      bus.mem_write      <= wr_nxt;
      bus.mem_writedata  <= wdata_nxt;
    end
  end

  // Read data returns one cycle after the address, so expectation is delayed to match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_vld  <= 1'b0;
      exp_q    <= '0;
      cmp_addr <= '0;
    end else begin
      cmp_vld  <= (state == S_RD0 || state == S_RD1) && !abort;
      exp_q    <= pattern(addr, state == S_RD1);
      cmp_addr <= addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
      have_fail <= 1'b0;
    end else begin
      done      <= (state == S_DRN1) && !abort;
      err_count <= err_nxt;
      if (launch) begin
        pass      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
        have_fail <= 1'b0;
      end else begin
        if (state == S_DRN1 && !abort)
          pass <= (err_nxt == 8'd0);
        if (mismatch && !have_fail) begin
          have_fail <= 1'b1;
          fail_addr <= cmp_addr;
          fail_data <= bus.mem_readdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_onchip_mem_bist_master.sv
// Directed bench for the RAM BIST master: fault-injecting RAM model plus result scoreboard.
module tb_onchip_mem_bist_master;
  localparam int          AW    = 10;
  localparam int          DEPTH = 1022;
  localparam int          BUSY_LEN = 4 * DEPTH + 2;
  localparam int          ACCESSES = 2 * DEPTH;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic          busy, done, pass;
  logic [7:0]    err_count;
  logic [AW-1:0] fail_addr;
  logic [31:0]   fail_data;

  onchip_mem_bist_master_if #(.ADDR_WIDTH(AW)) bus ();

  onchip_mem_bist_master #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .SEED(32'hA5C3_0F96)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // RAM model with selectable faults
  logic [31:0] ram [0:(1<<AW)-1];
  bit flt_stuck = 0, flt_alias = 0, flt_inject = 0;

  always @(posedge clk) begin
    if (bus.mem_chipselect && bus.mem_clken) begin
      if (bus.mem_write) begin
        ram[bus.mem_address] <= (flt_stuck && bus.mem_address == 10'h155) ?
                                (bus.mem_writedata & ~32'h80) : bus.mem_writedata;
        if (flt_alias && bus.mem_address == 10'h3FD) ram[0] <= bus.mem_writedata;
      end else begin
        bus.mem_readdata <= ram[bus.mem_address] ^
                            ((flt_inject && bus.mem_address < 10'd300) ? 32'h1 : 32'h0);
      end
    end
  end

  int busy_cnt = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0, oob_cnt = 0;
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (bus.mem_chipselect && bus.mem_write) wr_cnt++;
    if (bus.mem_chipselect && !bus.mem_write) rd_cnt++;
    if (bus.mem_chipselect && bus.mem_address > AW'(DEPTH - 1)) oob_cnt++;
  end

  typedef struct {
    logic          pass;
    logic [7:0]    errc;
    logic [AW-1:0] faddr;
    logic [31:0]   fdata;
  } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic p, input logic [7:0] e, input logic [AW-1:0] a,
                              input logic [31:0] d);
    exp_t r;
    r.pass = p; r.errc = e; r.faddr = a; r.fdata = d;
    return r;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_errc"}, err_count, 0);
    chk({tag, "_faddr"}, fail_addr, 0);
    chk({tag, "_fdata"}, fail_data, 0);
    chk({tag, "_maddr"}, bus.mem_address, 0);
    chk({tag, "_cs"}, bus.mem_chipselect, 0);
    chk({tag, "_wr"}, bus.mem_write, 0);
    chk({tag, "_wdata"}, bus.mem_writedata, 0);
  endtask

  // Drives one start pulse, waits for done and checks it against the queued expectation.
  task automatic run_test(input string tag, input exp_t e, input bit extra_starts);
    int b0, w0, r0, d0;
    bit got;
    exp_t x;
    sb.push_back(e);
    b0 = busy_cnt; w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 6000; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      start = extra_starts && (i == 500 || i == 2500);
      tick();
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, got, 1);
    x = sb.pop_front();
    chk({tag, "_pass"}, pass, x.pass);
    chk({tag, "_errc"}, err_count, x.errc);
    chk({tag, "_faddr"}, fail_addr, x.faddr);
    chk({tag, "_fdata"}, fail_data, x.fdata);
    chk({tag, "_busy_len"}, busy_cnt - b0, BUSY_LEN);
    chk({tag, "_writes"}, wr_cnt - w0, ACCESSES);
    chk({tag, "_reads"}, rd_cnt - r0, ACCESSES);
    tick();
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_done_low"}, done, 0);
  endtask

  initial begin
    int n, w0, d0;
    bit ok;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (2) tick();
    chk_reset_vals("rst");
    chk("byteenable", bus.mem_byteenable, 4'hF);
    chk("clken", bus.mem_clken, 1);
    reset = 1'b0;
    tick();

    run_test("clean", mk(1, 0, 0, 32'h0), 0);

    flt_stuck = 1;
    run_test("stuck7", mk(0, 1, 10'h155, 32'hA5C3_0E43), 0);
    flt_stuck = 0;

    flt_alias = 1;
    run_test("alias", mk(0, 2, 10'h000, 32'hA5C3_0C6B), 0);
    flt_alias = 0;

    // Abort at the 100th read cycle of the first pass
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.mem_chipselect && !bus.mem_write) n++;
      if (n == 100) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("abort_reach_rd", ok, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cs", bus.mem_chipselect, 0);
    chk("abort_wr", bus.mem_write, 0);
    chk("abort_pass", pass, 0);
    repeat (20) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    run_test("after_abort", mk(1, 0, 0, 32'h0), 0);

    // Asynchronous reset in the middle of the second write pass
    w0 = wr_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (wr_cnt - w0 >= DEPTH + 100) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("rst_reach_wr1", ok, 1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("midrst");
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("midrst_idle_cs", bus.mem_chipselect, 0);
    run_test("after_reset", mk(1, 0, 0, 32'h0), 0);

    flt_inject = 1;
    run_test("saturate", mk(0, 8'd255, 10'h000, 32'hA5C3_0F97), 1);
    flt_inject = 0;

    chk("addr_range", oob_cnt, 0);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
